// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port 8-bit memory between the instruction fetch
// port (F, read-only) and the data load/store port (D, read/write).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   fReq/fAddr/fGnt            fetch request, address, combinational grant
//   fRdata/fRvalid             registered fetch read data, one-cycle valid pulse
//   dReq/dWe/dAddr/dWdata/dGnt data request, write enable, address, write data, grant
//   dRdata/dRvalid             registered data read data, one-cycle valid pulse (reads only)
//   memAddr/memStoreAddr       memory read/write address (granted port, fAddr when idle)
//   memWrite/memDataIn         memory write strobe and write data
//   memDataOut                 combinational memory read data
//
// PRIORITY_MODE 0: D has priority, but after MAX_D_BURST consecutive D grants
// while F is waiting, F wins once. PRIORITY_MODE 1: round robin.
module mem_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned MAX_D_BURST   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fReq,
  input  logic [7:0] fAddr,
  output logic       fGnt,
  output logic [7:0] fRdata,
  output logic       fRvalid,
  input  logic       dReq,
  input  logic       dWe,
  input  logic [7:0] dAddr,
  input  logic [7:0] dWdata,
  output logic       dGnt,
  output logic [7:0] dRdata,
  output logic       dRvalid,
  output logic [7:0] memAddr,
  output logic [7:0] memStoreAddr,
  output logic       memWrite,
  output logic [7:0] memDataIn,
  input  logic [7:0] memDataOut
);

  typedef enum logic {
    GRANT_F = 1'b0,
    GRANT_D = 1'b1
  } last_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

  last_e      rr_last_q, rr_last_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] f_rdata_q, f_rdata_d;
  logic [7:0] d_rdata_q, d_rdata_d;
  logic       f_rvalid_q, f_rvalid_d;
  logic       d_rvalid_q, d_rvalid_d;

  logic       f_gnt, d_gnt, f_win;

  // Grant decision; forced off during reset so nothing transfers in a reset cycle.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    f_win = 1'b0;
    if (rst_n) begin
      if (fReq && dReq) begin
        if (PRIORITY_MODE == 0) begin
          f_win = (burst_cnt_q == BURST_MAX);
        end else begin
          f_win = (rr_last_q == GRANT_D);
        end
        f_gnt = f_win;
        d_gnt = !f_win;
      end else begin
        f_gnt = fReq;
        d_gnt = dReq;
      end
    end
  end

  always_comb begin
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    f_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;

    if (f_gnt) begin
      rr_last_d = GRANT_F;
    end else if (d_gnt) begin
      rr_last_d = GRANT_D;
    end

    // Counts D wins only while F is waiting; any F win or idle F restarts it.
    if (!fReq || f_gnt) begin
      burst_cnt_d = '0;
    end else if (d_gnt && (burst_cnt_q != BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end

    if (f_gnt) begin
      f_rdata_d  = memDataOut;
      f_rvalid_d = 1'b1;
    end
    if (d_gnt && !dWe) begin
      d_rdata_d  = memDataOut;
      d_rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last_q   <= GRANT_D;
      burst_cnt_q <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      f_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      f_rvalid_q  <= f_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  always_comb begin
    fGnt         = f_gnt;
    dGnt         = d_gnt;
    memAddr      = d_gnt ? dAddr : fAddr;
    memStoreAddr = d_gnt ? dAddr : fAddr;
    memWrite     = d_gnt & dWe;
    memDataIn    = dWdata;
    fRdata       = f_rdata_q;
    fRvalid      = f_rvalid_q;
    dRdata       = d_rdata_q;
    dRvalid      = d_rvalid_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance per PRIORITY_MODE driven by shared
// stimulus, each with its own memory; a reference model predicts every output.
module tb_mem_arbiter;

  localparam int MAXB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mem_init;
  logic       fReq, dReq, dWe;
  logic [7:0] fAddr, dAddr, dWdata;

  logic [1:0]      f_gnt, d_gnt, f_rvalid, d_rvalid, mem_write;
  logic [1:0][7:0] f_rdata, d_rdata, mem_addr, mem_store_addr, mem_data_in, mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] init_val(input int i);
    return (i == 16) ? 8'hAA : (8'(i) ^ 8'h5A);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [256];

    mem_arbiter #(.PRIORITY_MODE(g), .MAX_D_BURST(MAXB)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .fReq(fReq), .fAddr(fAddr), .fGnt(f_gnt[g]),
      .fRdata(f_rdata[g]), .fRvalid(f_rvalid[g]),
      .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dGnt(d_gnt[g]),
      .dRdata(d_rdata[g]), .dRvalid(d_rvalid[g]),
      .memAddr(mem_addr[g]), .memStoreAddr(mem_store_addr[g]),
      .memWrite(mem_write[g]), .memDataIn(mem_data_in[g]),
      .memDataOut(mem_data_out[g])
    );

    assign mem_data_out[g] = mem[mem_addr[g]];

    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (mem_write[g]) begin
        mem[mem_store_addr[g]] <= mem_data_in[g];
      end
    end
  end

  // Reference model: streak = D wins in a row while F waits; last_d = D won last.
  int         streak   [2];
  bit         last_d_m [2];
  bit         ef_v     [2];
  bit         ed_v     [2];
  logic [7:0] ef_d     [2];
  logic [7:0] ed_d     [2];
  logic [7:0] ref_mem  [2][256];

  function automatic void exp_grant(input int m, output bit gf, output bit gd);
    gf = 1'b0;
    gd = 1'b0;
    if (rst_n) begin
      if (fReq && dReq) begin
        if (m == 0) gf = (streak[m] >= MAXB);
        else        gf = last_d_m[m];
        gd = !gf;
      end else begin
        gf = fReq;
        gd = dReq;
      end
    end
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit gf, gd;
    for (int m = 0; m < 2; m++) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) ref_mem[m][i] = init_val(i);
      end
      exp_grant(m, gf, gd);
      if (!rst_n) begin
        streak[m]   = 0;
        last_d_m[m] = 1'b1;
        ef_v[m]     = 1'b0;
        ed_v[m]     = 1'b0;
        ef_d[m]     = 8'h00;
        ed_d[m]     = 8'h00;
      end else begin
        ef_v[m] = gf;
        ed_v[m] = gd && !dWe;
        if (gf) ef_d[m] = ref_mem[m][fAddr];
        if (gd && !dWe) ed_d[m] = ref_mem[m][dAddr];
        if (gd && dWe) ref_mem[m][dAddr] = dWdata;
        if (!fReq || gf) streak[m] = 0;
        else if (gd && streak[m] < MAXB) streak[m] = streak[m] + 1;
        if (gf) last_d_m[m] = 1'b0;
        else if (gd) last_d_m[m] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit gf, gd;
    if (!mem_init) begin
      for (int m = 0; m < 2; m++) begin
        exp_grant(m, gf, gd);
        check($sformatf("m%0d_fgnt", m),   8'(f_gnt[m]),          8'(gf));
        check($sformatf("m%0d_dgnt", m),   8'(d_gnt[m]),          8'(gd));
        check($sformatf("m%0d_onehot", m), 8'(f_gnt[m] & d_gnt[m]), 8'h00);
        check($sformatf("m%0d_write", m),  8'(mem_write[m]),      8'(gd && dWe));
        check($sformatf("m%0d_addr", m),   mem_addr[m],           gd ? dAddr : fAddr);
        check($sformatf("m%0d_saddr", m),  mem_store_addr[m],     gd ? dAddr : fAddr);
        check($sformatf("m%0d_din", m),    mem_data_in[m],        dWdata);
        check($sformatf("m%0d_frv", m),    8'(f_rvalid[m]),       8'(ef_v[m]));
        check($sformatf("m%0d_drv", m),    8'(d_rvalid[m]),       8'(ed_v[m]));
        check($sformatf("m%0d_frd", m),    f_rdata[m],            ef_d[m]);
        check($sformatf("m%0d_drd", m),    d_rdata[m],            ed_d[m]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] burst_f0, alt_f1;

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    fReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    fAddr = 8'h00; dAddr = 8'h00; dWdata = 8'h00;
    burst_f0 = 8'b1000_1000;  // mode 0: D,D,D,F,D,D,D,F (bit i = cycle i)
    alt_f1   = 8'b0101_0101;  // mode 1: F,D,F,D,...

    next_cycle();
    mem_init = 1'b0;
    @(negedge clk);
    check("rst_fgnt0",  8'(f_gnt[0]),    8'h00);
    check("rst_frv0",   8'(f_rvalid[0]), 8'h00);
    check("rst_drd1",   d_rdata[1],      8'h00);

    // Both requesting from reset: burst cap in mode 0, alternation in mode 1.
    next_cycle();
    rst_n = 1'b1;
    fReq = 1'b1; dReq = 1'b1; dWe = 1'b0; fAddr = 8'h10; dAddr = 8'h11;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("burst_f0_c%0d", c), 8'(f_gnt[0]), 8'(burst_f0[c]));
      check($sformatf("burst_d0_c%0d", c), 8'(d_gnt[0]), 8'(!burst_f0[c]));
      check($sformatf("alt_f1_c%0d", c),   8'(f_gnt[1]), 8'(alt_f1[c]));
      if (c == 4) begin
        check("burst_frv0_after_f", 8'(f_rvalid[0]), 8'h01);
        check("burst_frd0_after_f", f_rdata[0],      8'hAA);
      end
      next_cycle();
    end
    fReq = 1'b0; dReq = 1'b0;
    @(negedge clk);
    check("burst_frv0_last", 8'(f_rvalid[0]), 8'h01);

    // Single F read.
    next_cycle();
    fReq = 1'b1; fAddr = 8'h10;
    @(negedge clk);
    check("fread_gnt",  8'(f_gnt[0]), 8'h01);
    check("fread_addr", mem_addr[0],  8'h10);
    check("fread_dgnt", 8'(d_gnt[0]), 8'h00);
    next_cycle();
    fReq = 1'b0;
    @(negedge clk);
    check("fread_rv",   8'(f_rvalid[0]), 8'h01);
    check("fread_data", f_rdata[0],      8'hAA);

    // D write then read-back.
    next_cycle();
    dReq = 1'b1; dWe = 1'b1; dAddr = 8'h14; dWdata = 8'hBA;
    @(negedge clk);
    check("dwr_write", 8'(mem_write[0]), 8'h01);
    next_cycle();
    dWe = 1'b0;
    @(negedge clk);
    check("dwr_write_off", 8'(mem_write[0]), 8'h00);
    check("dwr_no_rv",     8'(d_rvalid[0]),  8'h00);
    next_cycle();
    dReq = 1'b0;
    @(negedge clk);
    check("drd_rv0",   8'(d_rvalid[0]), 8'h01);
    check("drd_data0", d_rdata[0],      8'hBA);
    check("drd_data1", d_rdata[1],      8'hBA);

    // Withdrawn F request after two D wins clears the burst count.
    next_cycle();
    fReq = 1'b1; dReq = 1'b1; fAddr = 8'h30; dAddr = 8'h11;
    next_cycle();
    next_cycle();
    fReq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("wd_dgnt_c%0d", c), 8'(d_gnt[0]), 8'h01);
      next_cycle();
    end
    fReq = 1'b1;
    @(negedge clk);
    check("wd_no_frv", 8'(f_rvalid[0]), 8'h00);
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      check($sformatf("wd_reraise_d_c%0d", c), 8'(d_gnt[0]), 8'h01);
      next_cycle();
    end
    @(negedge clk);
    check("wd_reraise_f", 8'(f_gnt[0]), 8'h01);
    next_cycle();
    fReq = 1'b0; dReq = 1'b0;

    // Reset asserted in the same cycle as a D write.
    next_cycle();
    rst_n = 1'b0; dReq = 1'b1; dWe = 1'b1; dAddr = 8'h20; dWdata = 8'h77;
    @(negedge clk);
    check("rstmid_dgnt0",  8'(d_gnt[0]),     8'h00);
    check("rstmid_dgnt1",  8'(d_gnt[1]),     8'h00);
    check("rstmid_write0", 8'(mem_write[0]), 8'h00);
    check("rstmid_write1", 8'(mem_write[1]), 8'h00);
    next_cycle();
    rst_n = 1'b1; dReq = 1'b0; dWe = 1'b0;
    @(negedge clk);
    check("rstmid_frv", 8'(f_rvalid[0] | f_rvalid[1]), 8'h00);
    check("rstmid_drv", 8'(d_rvalid[0] | d_rvalid[1]), 8'h00);
    check("rstmid_mem0", g_dut[0].mem[8'h20], 8'h7A);
    check("rstmid_mem1", g_dut[1].mem[8'h20], 8'h7A);

    // After reset, mode 1 gives F the first contest again.
    next_cycle();
    fReq = 1'b1; dReq = 1'b1; fAddr = 8'h10; dAddr = 8'h20;
    @(negedge clk);
    check("rr_after_rst_f1", 8'(f_gnt[1]), 8'h01);
    next_cycle();
    fReq = 1'b0; dReq = 1'b0;
    next_cycle();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
